// File: rtl/tank_game_pkg.sv
// Shared types and defaults for the tank game end-of-round controller.
// State encoding, winner codes and per-tank life/immunity defaults.
package tank_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_FINAL = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int LIVES_DEF   = 3;
  localparam int HOLDOFF_DEF = 30;

endpackage

// File: rtl/game_over_ctrl_if.sv
// Control/status bundle between the game core and the round controller.
// master drives the inputs (keyboard, hit detect, final timer).
interface game_over_ctrl_if;

  logic       start_key;
  logic       p1_hit;
  logic       p2_hit;
  logic       endgame;
  logic       startfinaltimer;
  logic       game_active;
  logic       show_gameover;
  logic [1:0] p1_lives;
  logic [1:0] p2_lives;
  logic [1:0] winner;

  modport master (
    output start_key, p1_hit, p2_hit, endgame,
    input  startfinaltimer, game_active, show_gameover,
    input  p1_lives, p2_lives, winner
  );

  modport slave (
    input  start_key, p1_hit, p2_hit, endgame,
    output startfinaltimer, game_active, show_gameover,
    output p1_lives, p2_lives, winner
  );

endinterface

// File: rtl/player_life_ctr.sv
// Per-tank lives register with post-hit immunity counter.
// fatal_o flags an accepted hit that takes the last life.
module player_life_ctr
  import tank_game_pkg::*;
#(
  parameter int LIVES   = LIVES_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       load_i,
  input  logic       play_i,
  input  logic       hit_i,
  output logic [1:0] lives_o,
  output logic       fatal_o
);

  logic [1:0] lives_q, lives_d;
  logic [7:0] hold_q, hold_d;
  logic       accept;

  assign accept  = play_i && hit_i &&
                   (hold_q == 8'd0) &&
                   (lives_q != 2'd0);
  assign fatal_o = accept && (lives_q == 2'd1);
  assign lives_o = lives_q;

  always_comb begin
    lives_d = lives_q;
    hold_d  = (hold_q != 8'd0) ?
              hold_q - 8'd1 : 8'd0;
    if (load_i) begin
      lives_d = 2'(LIVES);
      hold_d  = 8'd0;
    end else if (accept) begin
      lives_d = lives_q - 2'd1;
      hold_d  = 8'(HOLDOFF);
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lives_q <= 2'(LIVES);
      hold_q  <= 8'd0;
    end else begin
      lives_q <= lives_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/game_over_ctrl.sv
// Round sequencer: IDLE -> PLAY -> FINAL -> OVER, with winner decode.
// All outputs come straight from flops.
module game_over_ctrl
  import tank_game_pkg::*;
#(
  parameter int LIVES   = LIVES_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input logic               frame_clk,
  input logic               Reset_n,
  game_over_ctrl_if.slave   bus
);

  state_e     state_q, state_d;
  logic [1:0] win_q, win_d;
  logic       key_q;
  logic       sft_q, act_q, over_q;
  logic       start_edge;
  logic       load, play;
  logic       p1_fatal, p2_fatal;

  assign start_edge = bus.start_key && !key_q;
  assign load = start_edge &&
                (state_q == ST_IDLE ||
                 state_q == ST_OVER);
  assign play = (state_q == ST_PLAY);

  player_life_ctr #(
    .LIVES   (LIVES),
    .HOLDOFF (HOLDOFF)
  ) u_p1 (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .load_i    (load),
    .play_i    (play),
    .hit_i     (bus.p1_hit),
    .lives_o   (bus.p1_lives),
    .fatal_o   (p1_fatal)
  );

  player_life_ctr #(
    .LIVES   (LIVES),
    .HOLDOFF (HOLDOFF)
  ) u_p2 (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .load_i    (load),
    .play_i    (play),
    .hit_i     (bus.p2_hit),
    .lives_o   (bus.p2_lives),
    .fatal_o   (p2_fatal)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d = ST_PLAY;
          win_d   = WIN_NONE;
        end
      end
      ST_PLAY: begin
        if (p1_fatal || p2_fatal) begin
          state_d = ST_FINAL;
          if (p1_fatal && p2_fatal)
            win_d = WIN_DRAW;
          else if (p1_fatal)
            win_d = WIN_P2;
          else
            win_d = WIN_P1;
        end
      end
      ST_FINAL: begin
        if (bus.endgame)
          state_d = ST_OVER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so they line up with state_q.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      win_q   <= WIN_NONE;
      key_q   <= 1'b1;
      sft_q   <= 1'b0;
      act_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      key_q   <= bus.start_key;
      sft_q   <= (state_d == ST_FINAL);
      act_q   <= (state_d == ST_PLAY);
      over_q  <= (state_d == ST_OVER);
    end
  end

  assign bus.startfinaltimer = sft_q;
  assign bus.game_active     = act_q;
  assign bus.show_gameover   = over_q;
  assign bus.winner          = win_q;

endmodule

// File: tb/tb_game_over_ctrl.sv
// Directed bench for game_over_ctrl with LIVES=3, HOLDOFF=30.
// Inputs and checks happen 1 time unit after each rising edge.
module tb_game_over_ctrl;
  import tank_game_pkg::*;

  logic frame_clk;
  logic Reset_n;
  int   n_vec;
  int   n_err;

  game_over_ctrl_if bus ();

  game_over_ctrl #(
    .LIVES   (3),
    .HOLDOFF (30)
  ) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic hit(input logic a,
                     input logic b);
    bus.p1_hit = a;
    bus.p2_hit = b;
    cyc(1);
    bus.p1_hit = 1'b0;
    bus.p2_hit = 1'b0;
  endtask

  task automatic start();
    bus.start_key = 1'b1;
    cyc(1);
    bus.start_key = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset_n       = 1'b0;
    bus.start_key = 1'b0;
    bus.p1_hit    = 1'b0;
    bus.p2_hit    = 1'b0;
    bus.endgame   = 1'b0;
    #12;
    chk("rst_active", bus.game_active, 0);
    chk("rst_sft", bus.startfinaltimer, 0);
    chk("rst_over", bus.show_gameover, 0);
    chk("rst_p1", bus.p1_lives, 3);
    chk("rst_win", bus.winner, 0);
    Reset_n = 1'b1;
    cyc(1);
    chk("idle_active", bus.game_active, 0);

    // start, then p1 hits on frames 0, 10, 31
    start();
    chk("play_active", bus.game_active, 1);
    chk("play_p1", bus.p1_lives, 3);
    chk("play_p2", bus.p2_lives, 3);
    hit(1, 0);
    chk("p1_f0", bus.p1_lives, 2);
    cyc(9);
    hit(1, 0);
    chk("p1_f10_ign", bus.p1_lives, 2);
    cyc(20);
    hit(1, 0);
    chk("p1_f31", bus.p1_lives, 1);

    // start and endgame ignored in PLAY
    bus.endgame = 1'b1;
    start();
    bus.endgame = 1'b0;
    chk("play_keep", bus.game_active, 1);
    chk("play_nofin", bus.startfinaltimer, 0);
    chk("play_p1_keep", bus.p1_lives, 1);

    // p2 knocked out by three spaced hits
    hit(0, 1);
    chk("p2_h1", bus.p2_lives, 2);
    cyc(30);
    hit(0, 1);
    chk("p2_h2", bus.p2_lives, 1);
    cyc(30);
    hit(0, 1);
    chk("p2_h3", bus.p2_lives, 0);
    chk("p2_win", bus.winner, 1);
    chk("p2_sft", bus.startfinaltimer, 1);
    chk("p2_inact", bus.game_active, 0);

    // FINAL ignores hits and start
    cyc(31);
    hit(1, 0);
    chk("fin_p1_hold", bus.p1_lives, 1);
    start();
    chk("fin_keep", bus.startfinaltimer, 1);
    chk("fin_noplay", bus.game_active, 0);
    bus.endgame = 1'b1;
    cyc(1);
    bus.endgame = 1'b0;
    chk("over_show", bus.show_gameover, 1);
    chk("over_sft", bus.startfinaltimer, 0);
    cyc(3);
    chk("over_p1", bus.p1_lives, 1);
    chk("over_p2", bus.p2_lives, 0);
    chk("over_win", bus.winner, 1);

    // restart from OVER
    start();
    chk("re_active", bus.game_active, 1);
    chk("re_show", bus.show_gameover, 0);
    chk("re_p1", bus.p1_lives, 3);
    chk("re_p2", bus.p2_lives, 3);
    chk("re_win", bus.winner, 0);

    // draw: both reach 0 together
    hit(1, 1);
    cyc(30);
    hit(1, 1);
    chk("dr_p1", bus.p1_lives, 1);
    chk("dr_p2", bus.p2_lives, 1);
    cyc(30);
    hit(1, 1);
    chk("dr_win", bus.winner, 3);
    chk("dr_sft", bus.startfinaltimer, 1);
    chk("dr_lives", bus.p1_lives, 0);
    bus.endgame = 1'b1;
    cyc(1);
    bus.endgame = 1'b0;
    chk("dr_show", bus.show_gameover, 1);
    chk("dr_sft_off", bus.startfinaltimer, 0);

    // p1 dies while p2 takes a non-fatal hit
    start();
    hit(1, 0);
    cyc(30);
    hit(1, 0);
    chk("mx_p1a", bus.p1_lives, 1);
    chk("mx_p2a", bus.p2_lives, 3);
    cyc(30);
    hit(1, 1);
    chk("mx_p1", bus.p1_lives, 0);
    chk("mx_p2", bus.p2_lives, 2);
    chk("mx_win", bus.winner, 2);
    chk("mx_sft", bus.startfinaltimer, 1);

    // reset in FINAL with start_key held high
    bus.start_key = 1'b1;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_sft", bus.startfinaltimer, 0);
    chk("ar_win", bus.winner, 0);
    chk("ar_p1", bus.p1_lives, 3);
    cyc(2);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    cyc(2);
    chk("ar_idle", bus.game_active, 0);
    chk("ar_sft2", bus.startfinaltimer, 0);
    chk("ar_over", bus.show_gameover, 0);
    bus.start_key = 1'b0;
    cyc(1);
    start();
    chk("ar_start", bus.game_active, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
